decode_stage: RTL and testbench

- RV32I instruction decode stage. Sits between fetch and `execute`.
- Contains the 32x32 architectural register file, with a write port driven by writeback.
- Decodes the instruction and drives the ID/EX pipeline register: operand-select codes, ALU function, operand values, immediate, pc and control bits.
- Handles valid/ready stalls, branch flushes and load-use hazard bubbles.

---
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage.sv | 204 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch, writeback and ID/EX signals of the RV32I decode stage, bundled as one interface.
// The master side drives fetch/writeback/execute inputs; the slave side is the decode stage.
interface decode_stage_if #(
   parameter int WORD     = 32,
   parameter int ADDR_LEN = 32
);
   logic [31:0]         instr_i;
   logic [ADDR_LEN-1:0] pc_i;
   logic                in_valid;
   logic                in_ready;
   logic                wb_en;
   logic [4:0]          wb_rd;
   logic [WORD-1:0]     wb_data;
   logic                flush;
   logic                out_ready;
   logic                out_valid;
   logic [ADDR_LEN-1:0] pc_o;
   logic [1:0]          opsel1;
   logic [1:0]          opsel2;
   logic [3:0]          alu_func;
   logic [WORD-1:0]     rs1_value;
   logic [WORD-1:0]     rs2_value;
   logic [WORD-1:0]     imm;
   logic [4:0]          rd;
   logic                reg_write;
   logic                mem_read;
   logic                mem_write;
   logic                is_branch;
   logic                illegal;

   modport master (
      output instr_i, pc_i, in_valid, wb_en, wb_rd, wb_data, flush, out_ready,
      input  in_ready, out_valid, pc_o, opsel1, opsel2, alu_func, rs1_value, rs2_value,
             imm, rd, reg_write, mem_read, mem_write, is_branch, illegal
   );

   modport slave (
      input  instr_i, pc_i, in_valid, wb_en, wb_rd, wb_data, flush, out_ready,
      output in_ready, out_valid, pc_o, opsel1, opsel2, alu_func, rs1_value, rs2_value,
             imm, rd, reg_write, mem_read, mem_write, is_branch, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: architectural register file, instruction decode and the ID/EX register.
// Handles fetch/execute valid-ready stalls, branch flushes and load-use bubbles.
module decode_stage #(
   parameter int WORD     = 32,
   parameter int ADDR_LEN = 32,
   parameter int NREGS    = 32
) (
   input logic           clk,
   input logic           reset,
   decode_stage_if.slave bus
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [WORD-1:0] regs [NREGS];

   logic [31:0]     instr;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7b5;
   logic [4:0]      rs1_idx;
   logic [4:0]      rs2_idx;
   logic [4:0]      rd_idx;
   logic [WORD-1:0] rs1_read;
   logic [WORD-1:0] rs2_read;

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   logic [1:0]  dec_op1;
   logic [1:0]  dec_op2;
   logic [3:0]  dec_fn;
   logic [31:0] dec_imm;
   logic        dec_rw;
   logic        dec_mr;
   logic        dec_mw;
   logic        dec_br;
   logic        dec_ill;
   logic        use_rs1;
   logic        use_rs2;

   logic advance;
   logic hazard;

   assign instr    = bus.instr_i;
   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7b5 = instr[30];
   assign rs1_idx  = instr[19:15];
   assign rs2_idx  = instr[24:20];
   assign rd_idx   = instr[11:7];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // x0 stays zero because it is never written; writeback of the same cycle is bypassed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   always_comb begin
      rs1_read = '0;
      rs2_read = '0;
      if (rs1_idx != 5'd0) rs1_read = (bus.wb_en && bus.wb_rd == rs1_idx) ? bus.wb_data : regs[rs1_idx];
      if (rs2_idx != 5'd0) rs2_read = (bus.wb_en && bus.wb_rd == rs2_idx) ? bus.wb_data : regs[rs2_idx];
   end

   // Shift-immediates carry only the 5-bit shamt; funct7 selects SRA through alu_func instead.
   always_comb begin
      dec_op1 = 2'd0;
      dec_op2 = 2'd0;
      dec_fn  = 4'b0000;
      dec_imm = 32'd0;
      dec_rw  = 1'b0;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_br  = 1'b0;
      dec_ill = 1'b0;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            dec_fn  = {funct7b5, funct3};
            dec_rw  = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_IMM: begin
            dec_op2 = 2'd1;
            dec_fn  = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
            dec_imm = (funct3 == 3'b001 || funct3 == 3'b101) ? {27'd0, instr[24:20]} : imm_i;
            dec_rw  = 1'b1;
         end
         OP_LOAD: begin
            dec_op2 = 2'd1;
            dec_imm = imm_i;
            dec_mr  = 1'b1;
            dec_rw  = 1'b1;
         end
         OP_STORE: begin
            dec_op2 = 2'd1;
            dec_imm = imm_s;
            dec_mw  = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_BRANCH: begin
            dec_fn  = 4'b1000;
            dec_imm = imm_b;
            dec_br  = 1'b1;
            use_rs2 = 1'b1;
         end
         OP_LUI: begin
            dec_op1 = 2'd2;
            dec_op2 = 2'd1;
            dec_imm = imm_u;
            dec_rw  = 1'b1;
            use_rs1 = 1'b0;
         end
         OP_AUIPC: begin
            dec_op1 = 2'd1;
            dec_op2 = 2'd1;
            dec_imm = imm_u;
            dec_rw  = 1'b1;
            use_rs1 = 1'b0;
         end
         OP_JAL: begin
            dec_op1 = 2'd1;
            dec_op2 = 2'd2;
            dec_imm = imm_j;
            dec_br  = 1'b1;
            dec_rw  = 1'b1;
            use_rs1 = 1'b0;
         end
         OP_JALR: begin
            dec_op1 = 2'd1;
            dec_op2 = 2'd2;
            dec_imm = imm_i;
            dec_br  = 1'b1;
            dec_rw  = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
   end

   // A load still sitting in ID/EX cannot forward yet, so a dependent instruction waits one bubble.
   assign advance = bus.out_ready || !bus.out_valid;
   assign hazard  = bus.out_valid && bus.mem_read && (bus.rd != 5'd0) &&
                    ((bus.rd == rs1_idx && use_rs1) || (bus.rd == rs2_idx && use_rs2));
   assign bus.in_ready = bus.flush || (advance && !hazard);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.pc_o      <= {ADDR_LEN{1'b0}};
         bus.opsel1    <= 2'd0;
         bus.opsel2    <= 2'd0;
         bus.alu_func  <= 4'd0;
         bus.rs1_value <= '0;
         bus.rs2_value <= '0;
         bus.imm       <= '0;
         bus.rd        <= 5'd0;
         bus.reg_write <= 1'b0;
         bus.mem_read  <= 1'b0;
         bus.mem_write <= 1'b0;
         bus.is_branch <= 1'b0;
         bus.illegal   <= 1'b0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (advance && bus.in_valid && !hazard) begin
         bus.out_valid <= 1'b1;
         bus.pc_o      <= bus.pc_i;
         bus.opsel1    <= dec_op1;
         bus.opsel2    <= dec_op2;
         bus.alu_func  <= dec_fn;
         bus.rs1_value <= rs1_read;
         bus.rs2_value <= rs2_read;
         bus.imm       <= dec_imm;
         bus.rd        <= rd_idx;
         bus.reg_write <= dec_rw && (rd_idx != 5'd0);
         bus.mem_read  <= dec_mr;
         bus.mem_write <= dec_mw;
         bus.is_branch <= dec_br;
         bus.illegal   <= dec_ill;
      end else if (advance) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed RV32I cases followed by random traffic,
// each cycle compared against a reference model of the register file and ID/EX contents.
module tb_decode_stage;
   localparam int WORD     = 32;
   localparam int ADDR_LEN = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if #(.WORD(WORD), .ADDR_LEN(ADDR_LEN)) bus ();

   decode_stage #(.WORD(WORD), .ADDR_LEN(ADDR_LEN), .NREGS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  op1;
      logic [1:0]  op2;
      logic [3:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        br;
      logic        ill;
   } idex_t;

   idex_t       m;
   logic        m_valid;
   logic [31:0] mregs [32];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] read_ref(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
      return mregs[idx];
   endfunction

   // Reference decode written from the RV32I field layouts using signed arithmetic.
   function automatic idex_t decode_ref(input logic [31:0] ins, input logic [31:0] pc);
      idex_t d;
      logic [2:0] f3;
      f3 = ins[14:12];
      d.pc = pc; d.rd = ins[11:7];
      d.a = read_ref(ins[19:15]); d.b = read_ref(ins[24:20]);
      d.op1 = 0; d.op2 = 0; d.fn = 0; d.imm = 0;
      d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0; d.ill = 0;
      case (ins[6:0])
         7'h33: begin d.fn = {ins[30], f3}; d.rw = 1; end
         7'h13: begin
            d.op2 = 1; d.rw = 1;
            d.fn = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
            if (f3 == 3'd1 || f3 == 3'd5) d.imm = 32'(ins[24:20]);
            else d.imm = 32'($signed(ins[31:20]));
         end
         7'h03: begin d.op2 = 1; d.imm = 32'($signed(ins[31:20])); d.mr = 1; d.rw = 1; end
         7'h23: begin d.op2 = 1; d.imm = 32'($signed({ins[31:25], ins[11:7]})); d.mw = 1; end
         7'h63: begin
            d.fn = 4'b1000; d.br = 1;
            d.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         end
         7'h37: begin d.op1 = 2; d.op2 = 1; d.imm = ins & 32'hFFFF_F000; d.rw = 1; end
         7'h17: begin d.op1 = 1; d.op2 = 1; d.imm = ins & 32'hFFFF_F000; d.rw = 1; end
         7'h6F: begin
            d.op1 = 1; d.op2 = 2; d.br = 1; d.rw = 1;
            d.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         end
         7'h67: begin d.op1 = 1; d.op2 = 2; d.imm = 32'($signed(ins[31:20])); d.br = 1; d.rw = 1; end
         default: d.ill = 1;
      endcase
      if (d.rd == 5'd0) d.rw = 0;
      return d;
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
         chk({tag, ".pc_o"}, bus.pc_o, m.pc);
         chk({tag, ".opsel1"}, 32'(bus.opsel1), 32'(m.op1));
         chk({tag, ".opsel2"}, 32'(bus.opsel2), 32'(m.op2));
         chk({tag, ".alu_func"}, 32'(bus.alu_func), 32'(m.fn));
         chk({tag, ".rs1_value"}, bus.rs1_value, m.a);
         chk({tag, ".rs2_value"}, bus.rs2_value, m.b);
         chk({tag, ".imm"}, bus.imm, m.imm);
         chk({tag, ".rd"}, 32'(bus.rd), 32'(m.rd));
         chk({tag, ".ctrl"}, 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.is_branch, bus.illegal}),
             32'({m.rw, m.mr, m.mw, m.br, m.ill}));
      end
   endtask

   // Inputs are already applied at posedge+1; check in_ready, step the model across one edge, check outputs.
   task automatic cycle(input string tag);
      logic [6:0] op;
      logic adv, haz, u1, u2;
      idex_t nx;
      #1;
      op  = bus.instr_i[6:0];
      u1  = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
      u2  = (op == 7'h33 || op == 7'h23 || op == 7'h63);
      adv = bus.out_ready || !m_valid;
      haz = m_valid && m.mr && (m.rd != 5'd0) &&
            ((m.rd == bus.instr_i[19:15] && u1) || (m.rd == bus.instr_i[24:20] && u2));
      chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(bus.flush || (adv && !haz)));
      nx = decode_ref(bus.instr_i, bus.pc_i);
      @(posedge clk);
      if (bus.flush) m_valid = 1'b0;
      else if (adv && bus.in_valid && !haz) begin m = nx; m_valid = 1'b1; end
      else if (adv) m_valid = 1'b0;
      if (bus.wb_en && bus.wb_rd != 5'd0) mregs[bus.wb_rd] = bus.wb_data;
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      ins = $urandom;
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 10))
         0: ins[6:0] = 7'h33;
         1: ins[6:0] = 7'h13;
         2, 3: ins[6:0] = 7'h03;
         4: ins[6:0] = 7'h23;
         5: ins[6:0] = 7'h63;
         6: ins[6:0] = 7'h37;
         7: ins[6:0] = 7'h17;
         8: ins[6:0] = 7'h6F;
         9: ins[6:0] = 7'h67;
         default: ins[6:0] = 7'h7F;
      endcase
      return ins;
   endfunction

   task automatic set_in(input logic [31:0] ins, input logic [31:0] pc);
      bus.instr_i = ins; bus.pc_i = pc; bus.in_valid = 1'b1;
   endtask

   initial begin
      bus.instr_i = 0; bus.pc_i = 0; bus.in_valid = 0;
      bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
      bus.flush = 0; bus.out_ready = 1;
      m_valid = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;

      #12 reset = 1'b0;
      chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset.pc_o", bus.pc_o, 32'd0);
      chk("reset.imm", bus.imm, 32'd0);
      chk("reset.ctrl", 32'({bus.reg_write, bus.mem_read, bus.mem_write, bus.is_branch, bus.illegal}), 32'd0);
      @(posedge clk); #1;

      set_in(32'h0050_0093, 32'h10);
      cycle("addi");
      chk("addi.valid", 32'(bus.out_valid), 32'd1);
      chk("addi.opsel", 32'({bus.opsel1, bus.opsel2}), 32'b0001);
      chk("addi.imm", bus.imm, 32'd5);
      chk("addi.rd_rw", 32'({bus.rd, bus.reg_write}), 32'({5'd1, 1'b1}));
      chk("addi.pc", bus.pc_o, 32'h10);

      bus.wb_en = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'hDEAD;
      set_in(32'h0021_01B3, 32'h14);
      cycle("bypass");
      chk("bypass.rs1", bus.rs1_value, 32'hDEAD);
      chk("bypass.rs2", bus.rs2_value, 32'hDEAD);
      bus.wb_en = 0;

      set_in(32'h0000_A283, 32'h18);
      cycle("lw_x5");
      set_in(32'h0002_8333, 32'h1C);
      #1 chk("luse_rs1.in_ready", 32'(bus.in_ready), 32'd0);
      cycle("luse_rs1.bubble");
      chk("luse_rs1.bubble_valid", 32'(bus.out_valid), 32'd0);
      cycle("luse_rs1.issue");
      chk("luse_rs1.issue_rd", 32'({bus.out_valid, bus.rd}), 32'({1'b1, 5'd6}));

      set_in(32'h0000_A283, 32'h20);
      cycle("lw_x5b");
      set_in(32'h0050_0333, 32'h24);
      #1 chk("luse_rs2.in_ready", 32'(bus.in_ready), 32'd0);
      cycle("luse_rs2.bubble");
      cycle("luse_rs2.issue");

      set_in(32'h0000_A003, 32'h28);
      cycle("lw_x0");
      set_in(32'h0000_0333, 32'h2C);
      #1 chk("lw_x0.in_ready", 32'(bus.in_ready), 32'd1);
      cycle("lw_x0.use");

      set_in(32'h4031_00B3, 32'h30);
      cycle("sub");
      chk("sub.alu", 32'(bus.alu_func), 32'b1000);
      bus.out_ready = 0;
      set_in(32'h0050_0093, 32'h34);
      #1 chk("hold.in_ready", 32'(bus.in_ready), 32'd0);
      cycle("hold");
      chk("hold.alu", 32'(bus.alu_func), 32'b1000);
      chk("hold.pc", bus.pc_o, 32'h30);
      bus.flush = 1;
      cycle("flush_hold");
      chk("flush_hold.valid", 32'(bus.out_valid), 32'd0);
      bus.flush = 0; bus.out_ready = 1;

      set_in(32'h4020_D093, 32'h38);
      cycle("srai");
      chk("srai.alu", 32'(bus.alu_func), 32'b1101);
      chk("srai.imm", bus.imm, 32'd2);
      set_in(32'h0000_00FF, 32'h3C);
      cycle("illegal");
      chk("illegal.bits", 32'({bus.out_valid, bus.illegal, bus.reg_write}), 32'b110);

      for (int i = 0; i < 400; i++) begin
         bus.instr_i   = rand_instr();
         bus.pc_i      = 32'h100 + 32'(i) * 4;
         bus.in_valid  = ($urandom_range(0, 9) < 8);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 12) == 0);
         bus.wb_en     = $urandom_range(0, 1);
         bus.wb_rd     = 5'($urandom_range(0, 7));
         bus.wb_data   = $urandom;
         cycle("rand");
      end

      bus.flush = 0; bus.out_ready = 1; bus.in_valid = 0;
      bus.wb_en = 1; bus.wb_rd = 5'd1; bus.wb_data = 32'h1234;
      cycle("wb_x1");
      bus.wb_en = 0;
      set_in(32'h0000_83B3, 32'h40);
      cycle("read_x1");
      chk("read_x1.rs1", bus.rs1_value, 32'h1234);
      #3 reset = 1'b1;
      #1 chk("async_reset.valid", 32'(bus.out_valid), 32'd0);
      m_valid = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      #3 reset = 1'b0;
      cycle("after_reset");
      chk("after_reset.rs1", bus.rs1_value, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
